// File: rtl/multdiv_pkg.sv
// Shared types and constants for the iterative signed multiply/divide unit.
// Define MULTDIV_DIV_EN to build the divider; without it divide requests trap.
package multdiv_pkg;

    localparam int WIDTH_DEFAULT = 32;

    localparam int STATUS_MULT_OVF = 4;
    localparam int STATUS_DIV_ZERO = 5;

    // One datapath bit per cycle, so the 5-bit counter assumes WIDTH == 32.
    localparam logic [4:0] CNT_LAST = 5'd31;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
`ifdef MULTDIV_DIV_EN
        DIV  = 2'd3,
`endif
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/multdiv_if.sv
// Request/response bundle between the execute stage and the multiply/divide unit.
// Define MULTDIV_DIV_EN to enable the divider behind start_div.
interface multdiv_if
    import multdiv_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) ();

    // Handshake: a start is taken only in IDLE (start_mult wins over start_div);
    // busy is the combinational stall and is high while a start is pending or the
    // operation iterates; done pulses for exactly one cycle, and result/rd_out/
    // exception are meaningful only in that cycle, holding their value afterwards.
    logic             start_mult;
    logic             start_div;
    logic [WIDTH-1:0] operandA;
    logic [WIDTH-1:0] operandB;
    logic [4:0]       rd_in;
    logic             flush;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic [4:0]       rd_out;
    logic             exception;
    state_t           dbg_state;

    modport master (
        output start_mult, start_div, operandA, operandB, rd_in, flush,
        input  busy, done, result, rd_out, exception, dbg_state
    );

    modport slave (
        input  start_mult, start_div, operandA, operandB, rd_in, flush,
        output busy, done, result, rd_out, exception, dbg_state
    );

endinterface

// File: rtl/multdiv_dp.sv
// Iterative sign-magnitude datapath: shift-add multiply and restoring divide.
// The divider is only built when MULTDIV_DIV_EN is defined.
module multdiv_dp
    import multdiv_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_load,
    input  logic             i_is_div,
    input  logic             i_step,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_result,
    output logic             o_ovf
);

    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic [WIDTH-1:0]   r_opb;
    logic               r_neg;

    logic [WIDTH-1:0]   w_a_mag;
    logic [WIDTH-1:0]   w_b_mag;
    logic [WIDTH:0]     w_sum;
    logic [WIDTH-1:0]   w_mul_hi_n;
    logic [WIDTH-1:0]   w_mul_lo_n;
    logic [2*WIDTH-1:0] w_mag;
    logic [2*WIDTH-1:0] w_prod;
    logic               w_mul_ovf;
    logic [WIDTH-1:0]   w_hi_n;
    logic [WIDTH-1:0]   w_lo_n;

    assign w_a_mag = i_a[WIDTH-1] ? -i_a : i_a;
    assign w_b_mag = i_b[WIDTH-1] ? -i_b : i_b;

    // Multiply: r_lo holds the multiplier and shifts out as product bits enter.
    assign w_sum      = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_opb} : '0);
    assign w_mul_hi_n = w_sum[WIDTH:1];
    assign w_mul_lo_n = {w_sum[0], r_lo[WIDTH-1:1]};

    // Result is formed from the post-step values so it is ready on the last step.
    assign w_mag     = {w_mul_hi_n, w_mul_lo_n};
    assign w_prod    = r_neg ? -w_mag : w_mag;
    assign w_mul_ovf = ~((&w_prod[2*WIDTH-1:WIDTH-1]) | ~(|w_prod[2*WIDTH-1:WIDTH-1]));

`ifdef MULTDIV_DIV_EN
    logic             r_is_div;
    logic [WIDTH:0]   w_shift;
    logic [WIDTH:0]   w_diff;
    logic [WIDTH-1:0] w_div_hi_n;
    logic [WIDTH-1:0] w_div_lo_n;
    logic [WIDTH-1:0] w_quo;

    assign w_shift    = {r_hi, r_lo[WIDTH-1]};
    assign w_diff     = w_shift - {1'b0, r_opb};
    assign w_div_hi_n = w_diff[WIDTH] ? w_shift[WIDTH-1:0] : w_diff[WIDTH-1:0];
    assign w_div_lo_n = {r_lo[WIDTH-2:0], ~w_diff[WIDTH]};
    assign w_quo      = r_neg ? -w_div_lo_n : w_div_lo_n;

    assign w_hi_n   = r_is_div ? w_div_hi_n : w_mul_hi_n;
    assign w_lo_n   = r_is_div ? w_div_lo_n : w_mul_lo_n;
    assign o_result = r_is_div ? w_quo : w_prod[WIDTH-1:0];
    assign o_ovf    = ~r_is_div & w_mul_ovf;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_is_div <= 1'b0;
        end else if (i_load) begin
            r_is_div <= i_is_div;
        end
    end
`else
    logic w_unused_is_div;

    assign w_unused_is_div = i_is_div;
    assign w_hi_n          = w_mul_hi_n;
    assign w_lo_n          = w_mul_lo_n;
    assign o_result        = w_prod[WIDTH-1:0];
    assign o_ovf           = w_mul_ovf;
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_hi  <= '0;
            r_lo  <= '0;
            r_opb <= '0;
            r_neg <= 1'b0;
        end else if (i_load) begin
            r_hi  <= '0;
            r_lo  <= i_is_div ? w_a_mag : w_b_mag;
            r_opb <= i_is_div ? w_b_mag : w_a_mag;
            r_neg <= i_a[WIDTH-1] ^ i_b[WIDTH-1];
        end else if (i_step) begin
            r_hi <= w_hi_n;
            r_lo <= w_lo_n;
        end
    end

endmodule

// File: rtl/multdiv_ctrl.sv
// Multiply/divide controller: FSM, iteration counter and result latches.
// Define MULTDIV_DIV_EN to enable the DIV state; otherwise divides trap.
module multdiv_ctrl
    import multdiv_pkg::*;
#(
    parameter int         WIDTH     = WIDTH_DEFAULT,
    parameter logic [4:0] RD_STATUS = 5'd30
) (
    input  logic      clock,
    input  logic      reset,
    multdiv_if.slave  bus
);

    state_t           r_state;
    state_t           w_state_n;
    logic [4:0]       r_cnt;
    logic [4:0]       w_cnt_n;
    logic [4:0]       r_rd;
    logic [WIDTH-1:0] r_result;
    logic [4:0]       r_rd_out;
    logic             r_exc;

    logic             w_fin;
    logic [WIDTH-1:0] w_fin_result;
    logic [4:0]       w_fin_rd;
    logic             w_fin_exc;
    logic             w_start;
    logic             w_accept;
    logic             w_step;
    logic             w_div_trap;
    logic [WIDTH-1:0] w_dp_result;
    logic             w_dp_ovf;

    assign w_start  = bus.start_mult | bus.start_div;
    assign w_accept = (r_state == IDLE) && !bus.flush && w_start;

`ifdef MULTDIV_DIV_EN
    assign w_step     = (r_state == MUL) || (r_state == DIV);
    assign w_div_trap = (bus.operandB == '0);
`else
    assign w_step     = (r_state == MUL);
    assign w_div_trap = 1'b1;
`endif

    multdiv_dp #(.WIDTH(WIDTH)) u_dp (
        .i_clk    (clock),
        .i_rst_n  (reset),
        .i_load   (w_accept),
        .i_is_div (~bus.start_mult),
        .i_step   (w_step),
        .i_a      (bus.operandA),
        .i_b      (bus.operandB),
        .o_result (w_dp_result),
        .o_ovf    (w_dp_ovf)
    );

    always_comb begin
        w_state_n    = r_state;
        w_cnt_n      = r_cnt;
        w_fin        = 1'b0;
        w_fin_result = w_dp_result;
        w_fin_rd     = r_rd;
        w_fin_exc    = 1'b0;
        if (bus.flush) begin
            w_state_n = IDLE;
            w_cnt_n   = '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.start_mult) begin
                        w_state_n = MUL;
                    end else if (bus.start_div) begin
                        if (w_div_trap) begin
                            // Trap path: the rd of the request is not used.
                            w_state_n    = DONE;
                            w_fin        = 1'b1;
                            w_fin_result = WIDTH'(STATUS_DIV_ZERO);
                            w_fin_rd     = RD_STATUS;
                            w_fin_exc    = 1'b1;
                        end else begin
`ifdef MULTDIV_DIV_EN
                            w_state_n = DIV;
`endif
                        end
                    end
                end
                MUL: begin
                    w_cnt_n = r_cnt + 5'd1;
                    if (r_cnt == CNT_LAST) begin
                        w_state_n = DONE;
                        w_fin     = 1'b1;
                        if (w_dp_ovf) begin
                            w_fin_result = WIDTH'(STATUS_MULT_OVF);
                            w_fin_rd     = RD_STATUS;
                            w_fin_exc    = 1'b1;
                        end
                    end
                end
`ifdef MULTDIV_DIV_EN
                DIV: begin
                    w_cnt_n = r_cnt + 5'd1;
                    if (r_cnt == CNT_LAST) begin
                        w_state_n = DONE;
                        w_fin     = 1'b1;
                    end
                end
`endif
                DONE: begin
                    w_state_n = IDLE;
                end
                default: begin
                    w_state_n = IDLE;
                    w_cnt_n   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_rd     <= '0;
            r_result <= '0;
            r_rd_out <= '0;
            r_exc    <= 1'b0;
        end else begin
            r_state <= w_state_n;
            r_cnt   <= w_cnt_n;
            if (w_accept) begin
                r_rd <= bus.rd_in;
            end
            if (w_fin) begin
                r_result <= w_fin_result;
                r_rd_out <= w_fin_rd;
                r_exc    <= w_fin_exc;
            end
        end
    end

    assign bus.busy      = w_step || ((r_state == IDLE) && w_start);
    assign bus.done      = (r_state == DONE);
    assign bus.result    = r_result;
    assign bus.rd_out    = r_rd_out;
    assign bus.exception = r_exc;
    assign bus.dbg_state = r_state;

endmodule

// File: tb/tb_multdiv_ctrl.sv
// Directed self-checking bench for multdiv_ctrl (follows MULTDIV_DIV_EN when defined).
module tb_multdiv_ctrl;
  import multdiv_pkg::*;

  // clock / reset
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  multdiv_if #(.WIDTH(32)) bus ();

  multdiv_ctrl #(.WIDTH(32), .RD_STATUS(5'd30)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  // driver tasks
  task automatic idle_inputs();
    bus.start_mult = 1'b0;
    bus.start_div  = 1'b0;
    bus.operandA   = '0;
    bus.operandB   = '0;
    bus.rd_in      = '0;
    bus.flush      = 1'b0;
  endtask

  task automatic drive_start(input logic sm, input logic sd, input logic [31:0] a,
                             input logic [31:0] b, input logic [4:0] rd);
    bus.start_mult = sm;
    bus.start_div  = sd;
    bus.operandA   = a;
    bus.operandB   = b;
    bus.rd_in      = rd;
  endtask

  task automatic run_op(input string tag, input logic sm, input logic sd,
                        input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd,
                        input int exp_lat, input logic [31:0] exp_res,
                        input logic [4:0] exp_rd, input logic exp_exc);
    int n;
    int busy_cnt;
    logic seen;
    logic [31:0] exp_r;
    exp_q.push_back(exp_res);
    @(negedge clock);
    drive_start(sm, sd, a, b, rd);
    #1;
    check({tag, ".busy_at_start"}, 32'(bus.busy), 32'd1);
    busy_cnt = 1;
    seen = 1'b0;
    n = 0;
    for (int i = 1; i <= 40 && !seen; i++) begin
      @(negedge clock);
      bus.start_mult = 1'b0;
      bus.start_div  = 1'b0;
      #1;
      if (bus.done) begin
        seen = 1'b1;
        n = i;
        check({tag, ".busy_in_done"}, 32'(bus.busy), 32'd0);
      end else if (bus.busy) begin
        busy_cnt++;
      end
    end
    check({tag, ".done_seen"}, 32'(seen), 32'd1);
    check({tag, ".latency"}, n, exp_lat);
    check({tag, ".busy_cycles"}, busy_cnt, exp_lat);
    exp_r = exp_q.pop_front();
    check({tag, ".result"}, bus.result, exp_r);
    check({tag, ".rd_out"}, 32'(bus.rd_out), 32'(exp_rd));
    check({tag, ".exception"}, 32'(bus.exception), 32'(exp_exc));
    @(negedge clock);
    #1;
    check({tag, ".done_pulse_end"}, 32'(bus.done), 32'd0);
    check({tag, ".result_held"}, bus.result, exp_r);
  endtask

  task automatic start_and_wait(input int cycles, input logic [31:0] a, input logic [31:0] b);
    @(negedge clock);
    drive_start(1'b1, 1'b0, a, b, 5'd1);
    for (int i = 1; i < cycles; i++) begin
      @(negedge clock);
      bus.start_mult = 1'b0;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    #2 reset = 1'b0;
    #1;
    check("rst.state", 32'(bus.dbg_state), 32'(IDLE));
    check("rst.done", 32'(bus.done), 32'd0);
    check("rst.busy", 32'(bus.busy), 32'd0);
    check("rst.result", bus.result, 32'd0);
    check("rst.rd_out", 32'(bus.rd_out), 32'd0);
    check("rst.exception", 32'(bus.exception), 32'd0);
    repeat (2) @(negedge clock);
    reset = 1'b1;

    // multiply
    run_op("mul_7x-6", 1'b1, 1'b0, 32'd7, 32'hFFFF_FFFA, 5'd3, 33, 32'hFFFF_FFD6, 5'd3, 1'b0);
    run_op("mul_ovf", 1'b1, 1'b0, 32'h0001_0000, 32'h0001_0000, 5'd7, 33, 32'd4, 5'd30, 1'b1);
    run_op("mul_-5x-5", 1'b1, 1'b0, 32'hFFFF_FFFB, 32'hFFFF_FFFB, 5'd1, 33, 32'd25, 5'd1, 1'b0);
    run_op("mul_min_x1", 1'b1, 1'b0, 32'h8000_0000, 32'd1, 5'd2, 33, 32'h8000_0000, 5'd2, 1'b0);
    run_op("mul_min_x-1", 1'b1, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8, 33, 32'd4, 5'd30, 1'b1);
    run_op("both_starts", 1'b1, 1'b1, 32'd3, 32'd4, 5'd12, 33, 32'd12, 5'd12, 1'b0);

    // divide
`ifdef MULTDIV_DIV_EN
    run_op("div_-7/2", 1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2, 5'd9, 33, 32'hFFFF_FFFD, 5'd9, 1'b0);
    run_op("div_min/-1", 1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 5'd4, 33, 32'h8000_0000, 5'd4, 1'b0);
    run_op("div_100/-7", 1'b0, 1'b1, 32'd100, 32'hFFFF_FFF9, 5'd5, 33, 32'hFFFF_FFF2, 5'd5, 1'b0);
`else
    run_op("div_off_-7/2", 1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2, 5'd9, 1, 32'd5, 5'd30, 1'b1);
`endif
    run_op("div_by_zero", 1'b0, 1'b1, 32'd7, 32'd0, 5'd6, 1, 32'd5, 5'd30, 1'b1);

    // a start held high through DONE is not taken
    @(negedge clock);
    drive_start(1'b0, 1'b1, 32'd9, 32'd0, 5'd2);
    @(negedge clock);
    drive_start(1'b1, 1'b0, 32'd3, 32'd4, 5'd2);
    #1;
    check("done_start.done", 32'(bus.done), 32'd1);
    check("done_start.busy", 32'(bus.busy), 32'd0);
    @(negedge clock);
    bus.start_mult = 1'b0;
    #1;
    check("done_start.state", 32'(bus.dbg_state), 32'(IDLE));

    // flush wins over a start in the same cycle
    @(negedge clock);
    drive_start(1'b1, 1'b0, 32'd3, 32'd4, 5'd2);
    bus.flush = 1'b1;
    @(negedge clock);
    bus.start_mult = 1'b0;
    bus.flush = 1'b0;
    #1;
    check("flush_prio.state", 32'(bus.dbg_state), 32'(IDLE));

    // flush at cycle 10 of a multiply, then an immediate new start
    start_and_wait(10, 32'd5, 32'd6);
    bus.flush = 1'b1;
    @(negedge clock);
    bus.flush = 1'b0;
    #1;
    check("flush.state", 32'(bus.dbg_state), 32'(IDLE));
    check("flush.done", 32'(bus.done), 32'd0);
    run_op("after_flush", 1'b1, 1'b0, 32'h0001_2345, 32'h10, 5'd11, 33, 32'h0012_3450, 5'd11, 1'b0);

    // reset at cycle 10 of a multiply
    start_and_wait(10, 32'd5, 32'd6);
    reset = 1'b0;
    #1;
    check("midrst.state", 32'(bus.dbg_state), 32'(IDLE));
    check("midrst.done", 32'(bus.done), 32'd0);
    check("midrst.result", bus.result, 32'd0);
    check("midrst.rd_out", 32'(bus.rd_out), 32'd0);
    check("midrst.exception", 32'(bus.exception), 32'd0);
    @(negedge clock);
    reset = 1'b1;
    run_op("after_reset", 1'b1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd13, 33, 32'd1, 5'd13, 1'b0);

    // final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multdiv_ctrl.md
MULTDIV_CTRL -- requirements
Module: multdiv_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand and result width.
REQ-002 SHALL have parameter RD_STATUS, default 5'd30, status register index written on exception.
REQ-003 SHALL have port clock  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port start_mult  input  1  request signed multiply, sampled in IDLE.
REQ-006 SHALL have port start_div  input  1  request signed divide, sampled in IDLE.
REQ-007 SHALL have port operandA, operandB  input  WIDTH  forwarded operands from execute stage (A = multiplicand/dividend).
REQ-008 SHALL have port rd_in  input  5  destination register of the request.
REQ-009 SHALL have port flush  input  1  abort in-flight operation.
REQ-010 SHALL have port busy  output  1  pipeline stall request.
REQ-011 SHALL have port done  output  1  one-cycle result-valid pulse.
REQ-012 SHALL have ports result  output  WIDTH, rd_out  output  5, exception  output  1.

Function
REQ-013 SHALL implement states IDLE, MUL, DIV, DONE.
REQ-014 In IDLE, start_mult SHALL latch operands and rd_in and go to MUL; start_div alone SHALL go to DIV; both high SHALL select MUL.
REQ-015 MUL and DIV SHALL each run exactly 32 iterations (5-bit counter 0..31, wraps to 0 on exit), then go to DONE.
REQ-016 DONE SHALL last one cycle with done=1, then return to IDLE; a start in DONE SHALL be ignored.
REQ-017 Latency: acceptance edge to done high SHALL be 33 cycles.
REQ-018 busy SHALL be combinational: high in MUL or DIV, and in IDLE when start_mult or start_div is high; low in DONE.
REQ-019 start inputs SHALL be ignored outside IDLE.
REQ-020 Multiply SHALL produce low WIDTH bits of the signed product; exception when the 64-bit signed product does not fit in WIDTH bits.
REQ-021 Divide SHALL produce signed quotient truncated toward zero; 0x80000000 / -1 SHALL return 0x80000000 with no exception.
REQ-022 operandB == 0 on start_div SHALL go DIV-free to DONE on the next edge (latency 1) with exception.
REQ-023 On exception: rd_out = RD_STATUS, result = 4 (mult overflow) or 5 (divide by zero); otherwise rd_out = latched rd_in, result = computed value.
REQ-024 result, rd_out, exception SHALL be valid only while done=1 and held at last value otherwise.
REQ-025 flush SHALL force IDLE on the next edge from any state, suppress done, and take priority over start in the same cycle.

Reset
REQ-026 reset low SHALL immediately force IDLE, counter 0, result 0, rd_out 0, exception 0, done 0.
REQ-027 Reset mid-operation SHALL discard the operation with no done pulse.

Configuration
REQ-028 With MULTDIV_DIV_EN defined, divide SHALL behave per REQ-021/022.
REQ-029 Without MULTDIV_DIV_EN, DIV state and divider logic SHALL be absent; start_div SHALL go to DONE in 1 cycle with exception, rd_out = RD_STATUS, result = 5.

Structure
REQ-030 Package multdiv_pkg SHALL hold the state enum, WIDTH default, and status codes STATUS_MULT_OVF=4, STATUS_DIV_ZERO=5.
REQ-031 Iterative shift-add/restoring-divide datapath SHALL be a sub-module multdiv_dp; multdiv_ctrl holds FSM, counter, latches.

Verification
REQ-032 start_mult, A=7, B=-6, rd_in=3 -> busy 33 cycles, done at cycle 33, result=0xFFFFFFD6, rd_out=3, exception=0.
REQ-033 start_mult, A=0x10000, B=0x10000 -> done at cycle 33, result=4, rd_out=30, exception=1.
REQ-034 start_div, A=-7, B=2, rd_in=9 -> done at cycle 33, result=0xFFFFFFFD, rd_out=9; A=0x80000000, B=-1 -> result=0x80000000, exception=0.
REQ-035 start_div, B=0 -> done next cycle, result=5, rd_out=30, exception=1 (same response without MULTDIV_DIV_EN for any B).
REQ-036 flush at cycle 10 of a multiply, reset low at cycle 10 of another -> IDLE, no done pulse, new start accepted immediately after.
